// File: rtl/axis_frame_stats_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_stats_if
//  Description : AXI4-Stream image beat bundle (16-bit pixel, valid, ready,
//                last) with master/slave views for axis_frame_stats.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_frame_stats_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_frame_stats.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_stats
//  Description : One-stage AXI4-Stream register slice for the averaged image
//                stream, with per-frame min/max/sum/count statistics, line
//                length / frame height checking and abort detection.
//                Optional macro AXIS_FRAME_STATS_SATCNT_EN adds stats_sat,
//                the per-frame count of full-scale pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_stats #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int DATA_BITS    = 14
) (
    input  wire logic                 axis_aclk,
    input  wire logic                 axis_aresetn,
    input  wire logic                 sof_in,
    axis_frame_stats_if.slave         s_axis,
    axis_frame_stats_if.master        m_axis,
    output logic [DATA_BITS-1:0]      stats_min,
    output logic [DATA_BITS-1:0]      stats_max,
    output logic [39:0]               stats_sum,
    output logic [23:0]               stats_cnt,
`ifdef AXIS_FRAME_STATS_SATCNT_EN
    output logic [23:0]               stats_sat,
`endif
    output logic                      stats_valid,
    output logic                      stats_err,
    output logic                      frame_abort
);

    // Column counter must be able to hold FRAME_WIDTH (saturation value).
    localparam int COL_W  = $clog2(FRAME_WIDTH + 1);
    localparam int LINE_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    localparam logic [COL_W-1:0]     c_COL_FULL  = COL_W'(FRAME_WIDTH);
    localparam logic [COL_W-1:0]     c_COL_LAST  = COL_W'(FRAME_WIDTH - 1);
    localparam logic [LINE_W-1:0]    c_LINE_LAST = LINE_W'(FRAME_HEIGHT - 1);
    localparam logic [DATA_BITS-1:0] c_PIX_ONES  = '1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_ACC  = 1'b1;

    // ------------------------------------------------------------------
    // Register slice
    // ------------------------------------------------------------------
    logic        m_valid_q;
    logic [15:0] m_data_q;
    logic        m_last_q;
    logic        w_s_ready;
    logic        w_accept;

    assign w_s_ready     = ~m_valid_q | m_axis.tready;
    assign w_accept      = s_axis.tvalid & w_s_ready;
    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tlast  = m_last_q;

    // Load on every accepted beat; drop valid once the held beat is taken.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (w_accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis.tdata;
            m_last_q  <= s_axis.tlast;
        end else if (m_axis.tready) begin
            m_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame accumulators
    // ------------------------------------------------------------------
    logic [0:0]           state_q, state_d;
    logic [DATA_BITS-1:0] min_q, min_d, max_q, max_d;
    logic [39:0]          sum_q, sum_d;
    logic [23:0]          cnt_q, cnt_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [LINE_W-1:0]    line_q, line_d;
    logic                 err_q, err_d;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
    logic [23:0]          sat_q, sat_d, src_sat, upd_sat;
`endif

    logic [DATA_BITS-1:0] w_v;
    logic                 w_done;
    logic                 w_fresh;
    logic [DATA_BITS-1:0] src_min, src_max, upd_min, upd_max;
    logic [39:0]          src_sum, upd_sum;
    logic [23:0]          src_cnt, upd_cnt;
    logic [COL_W-1:0]     src_col, upd_col;
    logic [LINE_W-1:0]    src_line, upd_line;
    logic                 src_err, upd_err;

    assign w_v    = s_axis.tdata[DATA_BITS-1:0];
    assign w_done = (state_q == c_ST_ACC) & w_accept & s_axis.tlast &
                    (line_q == c_LINE_LAST);
    // A start-of-frame that does not coincide with completion restarts the
    // accumulation; a coinciding beat then becomes the first pixel.
    assign w_fresh = sof_in & ~w_done;

    // Per-beat update applied to either the running or the freshly cleared set.
    always_comb begin
        src_min  = w_fresh ? '1 : min_q;
        src_max  = w_fresh ? '0 : max_q;
        src_sum  = w_fresh ? '0 : sum_q;
        src_cnt  = w_fresh ? '0 : cnt_q;
        src_col  = w_fresh ? '0 : col_q;
        src_line = w_fresh ? '0 : line_q;
        src_err  = w_fresh ? 1'b0 : err_q;
        upd_min  = (w_v < src_min) ? w_v : src_min;
        upd_max  = (w_v > src_max) ? w_v : src_max;
        upd_sum  = src_sum + 40'(w_v);
        upd_cnt  = src_cnt + 24'd1;
        upd_err  = src_err | (s_axis.tlast ? (src_col != c_COL_LAST)
                                           : (src_col >= c_COL_LAST));
        upd_col  = s_axis.tlast ? '0
                 : ((src_col == c_COL_FULL) ? c_COL_FULL : src_col + 1'b1);
        upd_line = s_axis.tlast ? ((src_line == c_LINE_LAST) ? '0 : src_line + 1'b1)
                                : src_line;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
        src_sat  = w_fresh ? '0 : sat_q;
        upd_sat  = src_sat + 24'(w_v == c_PIX_ONES);
`endif
    end

    // Next-state selection: clear on SOF, update on counted beats, hold otherwise.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        line_d  = line_q;
        err_d   = err_q;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
        sat_d   = sat_q;
`endif
        if (sof_in && (w_done || !w_accept)) begin
            state_d = c_ST_ACC;
            min_d   = '1;
            max_d   = '0;
            sum_d   = '0;
            cnt_d   = '0;
            col_d   = '0;
            line_d  = '0;
            err_d   = 1'b0;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
            sat_d   = '0;
`endif
        end else if (w_accept && (sof_in || state_q == c_ST_ACC)) begin
            state_d = w_done ? c_ST_IDLE : c_ST_ACC;
            min_d   = upd_min;
            max_d   = upd_max;
            sum_d   = upd_sum;
            cnt_d   = upd_cnt;
            col_d   = upd_col;
            line_d  = upd_line;
            err_d   = upd_err;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
            sat_d   = upd_sat;
`endif
        end
    end

    // Accumulator and FSM state registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q <= c_ST_IDLE;
            min_q   <= '1;
            max_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
            sat_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            line_q  <= line_d;
            err_q   <= err_d;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Result latch and strobes
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] st_min_q, st_max_q;
    logic [39:0]          st_sum_q;
    logic [23:0]          st_cnt_q;
    logic                 st_err_q, st_valid_q, abort_q;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
    logic [23:0]          st_sat_q;
`endif

    // Capture the final values (including the completing beat) and pulse.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            st_min_q   <= '0;
            st_max_q   <= '0;
            st_sum_q   <= '0;
            st_cnt_q   <= '0;
            st_err_q   <= 1'b0;
            st_valid_q <= 1'b0;
            abort_q    <= 1'b0;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
            st_sat_q   <= '0;
`endif
        end else begin
            st_valid_q <= w_done;
            abort_q    <= sof_in & (state_q == c_ST_ACC) & ~w_done;
            if (w_done) begin
                st_min_q <= upd_min;
                st_max_q <= upd_max;
                st_sum_q <= upd_sum;
                st_cnt_q <= upd_cnt;
                st_err_q <= upd_err;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
                st_sat_q <= upd_sat;
`endif
            end
        end
    end

    assign stats_min   = st_min_q;
    assign stats_max   = st_max_q;
    assign stats_sum   = st_sum_q;
    assign stats_cnt   = st_cnt_q;
    assign stats_err   = st_err_q;
    assign stats_valid = st_valid_q;
    assign frame_abort = abort_q;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
    assign stats_sat   = st_sat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_frame_stats
//  Description : Directed self-checking bench for axis_frame_stats with a
//                scoreboard for pass-through beats and frame statistics.
//                Build with AXIS_FRAME_STATS_SATCNT_EN to cover stats_sat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_stats;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk;
    logic        axis_aresetn;
    logic        sof_in;
    logic [13:0] stats_min, stats_max;
    logic [39:0] stats_sum;
    logic [23:0] stats_cnt;
    logic        stats_valid, stats_err, frame_abort;
`ifdef AXIS_FRAME_STATS_SATCNT_EN
    logic [23:0] stats_sat;
`endif

    axis_frame_stats_if s_if ();
    axis_frame_stats_if m_if ();

    axis_frame_stats #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .DATA_BITS(14)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (axis_aresetn),
        .sof_in       (sof_in),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .stats_min    (stats_min),
        .stats_max    (stats_max),
        .stats_sum    (stats_sum),
        .stats_cnt    (stats_cnt),
`ifdef AXIS_FRAME_STATS_SATCNT_EN
        .stats_sat    (stats_sat),
`endif
        .stats_valid  (stats_valid),
        .stats_err    (stats_err),
        .frame_abort  (frame_abort)
    );

    typedef struct {
        logic [13:0] mn;
        logic [13:0] mx;
        logic [39:0] sum;
        logic [23:0] cnt;
        logic        err;
        logic [23:0] sat;
    } st_t;

    st_t         exp_q[$];
    logic [16:0] beat_q[$];
    int          total = 0;
    int          bad   = 0;
    int          abort_cnt = 0;
    int          sv_cnt    = 0;
    bit          bp_en = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: constant 1, or toggling every cycle under backpressure.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = bp_en ? ~m_if.tready : 1'b1;
        end
    end

    // Monitor: output beats, stall stability, stats results, abort pulses.
    initial begin
        bit          prev_stall = 0;
        logic [16:0] prev_beat  = '0;
        logic [16:0] e;
        st_t         s;
        forever begin
            @(negedge clk);
            if (!axis_aresetn) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", m_if.tvalid, 1);
                    chk("stall_beat", {m_if.tlast, m_if.tdata}, prev_beat);
                end
                prev_stall = m_if.tvalid & ~m_if.tready;
                prev_beat  = {m_if.tlast, m_if.tdata};
                if (m_if.tvalid && m_if.tready) begin
                    if (beat_q.size() == 0) begin
                        chk("out_unexpected", m_if.tvalid, 0);
                    end else begin
                        e = beat_q.pop_front();
                        chk("out_beat", {m_if.tlast, m_if.tdata}, e);
                    end
                end
                if (stats_valid) begin
                    sv_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("stats_unexpected", stats_valid, 0);
                    end else begin
                        s = exp_q.pop_front();
                        chk("stats_min", stats_min, s.mn);
                        chk("stats_max", stats_max, s.mx);
                        chk("stats_sum", stats_sum, s.sum);
                        chk("stats_cnt", stats_cnt, s.cnt);
                        chk("stats_err", stats_err, s.err);
`ifdef AXIS_FRAME_STATS_SATCNT_EN
                        chk("stats_sat", stats_sat, s.sat);
`endif
                    end
                end
                if (frame_abort) abort_cnt++;
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit last, input bit sof);
        bit acc = 0;
        s_if.tdata  = d;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        sof_in      = sof;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            sof_in = 1'b0;
        end
        chk("send_accepted", acc, 1);
        if (acc) beat_q.push_back({last, d});
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] p[8]);
        for (int i = 0; i < 8; i++) send(p[i], (i % W) == W - 1, 1'b0);
    endtask

    task automatic pulse_sof();
        sof_in = 1'b1;
        @(posedge clk);
        #1;
        sof_in = 1'b0;
    endtask

    task automatic expect_stats(input int mn, input int mx, input longint sum,
                                input int cnt, input bit err, input int sat);
        st_t s;
        s.mn = 14'(mn); s.mx = 14'(mx); s.sum = 40'(sum);
        s.cnt = 24'(cnt); s.err = err; s.sat = 24'(sat);
        exp_q.push_back(s);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && beat_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_beats", beat_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_m_valid"}, m_if.tvalid, 0);
        chk({tag, "_m_data"},  m_if.tdata, 0);
        chk({tag, "_m_last"},  m_if.tlast, 0);
        chk({tag, "_s_ready"}, s_if.tready, 1);
        chk({tag, "_stats"},   {stats_min, stats_max, stats_cnt}, 0);
        chk({tag, "_sum"},     stats_sum, 0);
        chk({tag, "_flags"},   {stats_valid, stats_err, frame_abort}, 0);
`ifdef AXIS_FRAME_STATS_SATCNT_EN
        chk({tag, "_sat"},     stats_sat, 0);
`endif
    endtask

    initial begin
        logic [15:0] f[8];
        axis_frame_stats_if_dummy_guard: begin end
        axis_aresetn = 1'b0;
        sof_in       = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tlast   = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        axis_aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", s_if.tready, 1);

        // 1: sanity frame
        expect_stats(5, 16383, 16501, 8, 0, 1);
        pulse_sof();
        send(16'd10, 1'b0, 1'b0);
        chk("latency_valid", m_if.tvalid, 1);
        chk("latency_data", m_if.tdata, 16'd10);
        f = '{16'd20, 16'd30, 16'd40, 16'd5, 16'd6, 16'd7, 16'd16383, 16'd0};
        send(f[0], 0, 0); send(f[1], 0, 0); send(f[2], 1, 0);
        send(f[3], 0, 0); send(f[4], 0, 0); send(f[5], 0, 0); send(f[6], 1, 0);
        chk("t1_valid_timing", stats_valid, 1);
        chk("t1_sum_timing", stats_sum, 40'd16501);
        drain();

        // 2: same frame under toggling backpressure, upper tdata bits set
        expect_stats(5, 16383, 16501, 8, 0, 1);
        bp_en = 1;
        pulse_sof();
        f = '{16'hC00A, 16'd20, 16'd30, 16'd40, 16'd5, 16'd6, 16'd7, 16'd16383};
        send_frame(f);
        bp_en = 0;
        drain();

        // 3: short first line
        expect_stats(1, 7, 28, 7, 1, 0);
        pulse_sof();
        send(16'd1, 0, 0); send(16'd2, 0, 0); send(16'd3, 1, 0);
        send(16'd4, 0, 0); send(16'd5, 0, 0); send(16'd6, 0, 0); send(16'd7, 1, 0);
        drain();

        // 4: abort after five beats, then a full frame of 100s
        pulse_sof();
        for (int i = 0; i < 5; i++) send(16'd50, i == W - 1, 1'b0);
        pulse_sof();
        chk("t4_abort_pulse", frame_abort, 1);
        expect_stats(100, 100, 800, 8, 0, 0);
        f = '{default: 16'd100};
        send_frame(f);
        drain();

        // 5a: SOF coincident with the first beat
        expect_stats(9, 80, 359, 8, 0, 0);
        send(16'd9, 0, 1);
        send(16'd20, 0, 0); send(16'd30, 0, 0); send(16'd40, 1, 0);
        send(16'd50, 0, 0); send(16'd60, 0, 0); send(16'd70, 0, 0); send(16'd80, 1, 0);
        drain();

        // 5b: SOF coincident with the completing beat starts the next frame
        expect_stats(1, 2, 9, 8, 0, 0);
        expect_stats(3, 3, 24, 8, 0, 0);
        pulse_sof();
        for (int i = 0; i < 7; i++) send(16'd1, i == W - 1, 1'b0);
        send(16'd2, 1, 1);
        f = '{default: 16'd3};
        send_frame(f);
        drain();

        // 5c: asynchronous reset mid-frame
        pulse_sof();
        send(16'd11, 0, 0); send(16'd12, 0, 0); send(16'd13, 0, 0);
        #2;
        axis_aresetn = 1'b0;
        beat_q.delete();
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        axis_aresetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_valid", stats_valid, 0);

        // 6: full-scale pixels; beats before SOF are not counted
        send(16'd16383, 0, 0); send(16'd16383, 1, 0);
        expect_stats(1, 16383, 49164, 8, 0, 3);
        pulse_sof();
        f = '{16'd16383, 16'd1, 16'd16383, 16'd2, 16'd16383, 16'd3, 16'd4, 16'd5};
        send_frame(f);
        drain();

        chk("stats_pending", exp_q.size(), 0);
        chk("stats_count", sv_cnt, 8);
        chk("abort_count", abort_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
